counter_event_monitor: RTL
==========================

COUNTER_EVENT_MONITOR -- requirements
Module: counter_event_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the monitored counter value.
REQ-002 SHALL have parameter EVT_W, default 8, width of the event counter.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cnt_in  input  CNT_W  counter value from the upstream up-counter.
REQ-006 SHALL have port ovf_in  input  1  upstream overflow flag; sticky high until upstream reset.
REQ-007 SHALL have port cmp_value  input  CNT_W  compare threshold.
REQ-008 SHALL have port cmp_en  input  1  compare-event enable.
REQ-009 SHALL have port irq_ack  input  1  interrupt acknowledge, four-phase handshake.
REQ-010 SHALL have port evt_clr  input  1  clears evt_count and evt_sat.
REQ-011 SHALL have port irq_req  output  1  interrupt request, registered.
REQ-012 SHALL have port irq_cause  output  2  bit0 overflow, bit1 compare; registered.
REQ-013 SHALL have port evt_count  output  EVT_W  saturating count of detected events.
REQ-014 SHALL have port evt_sat  output  1  high once evt_count has saturated.
REQ-015 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 SHALL register ovf_in as ovf_d; overflow event = ovf_in & ~ovf_d (rising edge only).
REQ-017 SHALL define match = cmp_en & (cnt_in == cmp_value), register it as match_d; compare event = match & ~match_d.
REQ-018 SHALL implement FSM states IDLE, REQ, ACKW (2-bit encoding, unused code -> IDLE).
REQ-019 IDLE: if (pend | new events) != 0 -> REQ; irq_cause <= pend | new events; pend <= 0.
REQ-020 REQ: irq_req = 1; irq_cause held stable; on irq_ack = 1 -> ACKW.
REQ-021 ACKW: irq_req = 0; on irq_ack = 0 -> IDLE.
REQ-022 Latency: irq_req SHALL be high in the cycle after the edge at which the event is first detected in IDLE with pend = 0.
REQ-023 Events detected in REQ or ACKW SHALL be OR-ed into pend[1:0] and never lost; repeated same-type events merge.
REQ-024 Events detected on the ACKW->IDLE edge SHALL go to pend and raise a new REQ one cycle later.
REQ-025 irq_cause SHALL be 0 in IDLE and ACKW.
REQ-026 evt_count SHALL add the number of events detected per cycle (0, 1 or 2), saturating at 2^EVT_W-1.
REQ-027 evt_sat SHALL set when evt_count reaches 2^EVT_W-1 and stay set until evt_clr or reset.
REQ-028 evt_clr with simultaneous events: evt_count <= number of events that cycle; evt_sat <= 0.
REQ-029 Event detection and counting SHALL be independent of FSM state and of irq_ack.
REQ-030 irq_ack high in IDLE SHALL be ignored.

Reset
REQ-031 On reset: FSM=IDLE, irq_req=0, irq_cause=0, pend=0, evt_count=0, evt_sat=0, busy=0.
REQ-032 On reset: ovf_d=0, match_d=0; reset SHALL override all other inputs, including mid-handshake.
REQ-033 If ovf_in is still 1 on the first cycle after reset, one overflow event SHALL be detected.

Verification
REQ-034 cnt_in ramps 0..15, ovf_in rises at cnt_in=15 -> irq_req=1 next cycle, irq_cause=01, evt_count=1.
REQ-035 cmp_en=1, cmp_value=5, cnt_in holds 5 for 3 cycles -> exactly one event, irq_cause=10, evt_count=1.
REQ-036 Overflow and compare on the same edge -> irq_cause=11, evt_count=2.
REQ-037 Compare event during REQ, then ack high/low -> IDLE 1 cycle, second REQ with irq_cause=10.
REQ-038 300 events with no clear -> evt_count=255, evt_sat=1; evt_clr plus event -> evt_count=1, evt_sat=0.
REQ-039 reset asserted in ACKW with pend=01 -> all outputs 0 next cycle, no further irq_req.

Source files
------------

// File: rtl/counter_event_monitor.sv
// Watches an upstream counter for overflow and compare-match edges, raises a
// four-phase interrupt handshake and keeps a saturating count of events.
module counter_event_monitor #(
    parameter int CNT_W = 4,
    parameter int EVT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             ovf_in,
    input  logic [CNT_W-1:0] cmp_value,
    input  logic             cmp_en,
    input  logic             irq_ack,
    input  logic             evt_clr,
    output logic             irq_req,
    output logic [1:0]       irq_cause,
    output logic [EVT_W-1:0] evt_count,
    output logic             evt_sat,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACKW = 2'd2
    } state_t;

    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    state_t         state, state_nxt;
    logic           ovf_d, match_d, match;
    logic [1:0]     new_evt, pend, pend_nxt, cause_nxt;
    logic [1:0]     evt_num;
    logic [EVT_W:0] count_sum;

    // Only rising edges of the sticky overflow flag and of the match condition count as events
    assign match     = cmp_en & (cnt_in == cmp_value);
    assign new_evt   = {match & ~match_d, ovf_in & ~ovf_d};
    assign evt_num   = {1'b0, new_evt[0]} + {1'b0, new_evt[1]};
    assign count_sum = {1'b0, evt_count} + (EVT_W+1)'(evt_num);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend | new_evt;
        cause_nxt = irq_cause;
        case (state)
            IDLE: begin
                cause_nxt = 2'b00;
                if ((pend | new_evt) != 2'b00) begin
                    state_nxt = REQ;
                    cause_nxt = pend | new_evt;
                    pend_nxt  = 2'b00;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_nxt = ACKW;
                    cause_nxt = 2'b00;
                end
            end
            ACKW: begin
                cause_nxt = 2'b00;
                if (!irq_ack) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cause_nxt = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            irq_req   <= 1'b0;
            irq_cause <= 2'b00;
            pend      <= 2'b00;
            ovf_d     <= 1'b0;
            match_d   <= 1'b0;
            evt_count <= '0;
            evt_sat   <= 1'b0;
        end else begin
            state     <= state_nxt;
            irq_req   <= (state_nxt == REQ);
            irq_cause <= cause_nxt;
            pend      <= pend_nxt;
            ovf_d     <= ovf_in;
            match_d   <= match;
            // A clear restarts counting from this cycle's events rather than dropping them
            if (evt_clr) begin
                evt_count <= EVT_W'(evt_num);
                evt_sat   <= 1'b0;
            end else if (count_sum >= {1'b0, EVT_MAX}) begin
                evt_count <= EVT_MAX;
                evt_sat   <= 1'b1;
            end else begin
                evt_count <= count_sum[EVT_W-1:0];
            end
        end
    end

endmodule
